obi_host_initiator: RTL and testbench

OBI_HOST_INITIATOR -- requirements
Module: obi_host_initiator

---
 rtl/obi_host_pkg.sv | 7 +
 rtl/obi_host_initiator.sv | 104 ++++++++++
 tb/tb_obi_host_initiator.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/obi_host_pkg.sv
// obi_host_pkg: shared state encoding and default sizing for the OBI host initiator.
package obi_host_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_TIMEOUT    = 255;
endpackage

// File: rtl/obi_host_initiator.sv
// obi_host_initiator: turns one host command at a time into an OBI request/response
// transaction, with a bounded wait that aborts with an error response.
module obi_host_initiator
   import obi_host_pkg::*;
#(
   parameter int pADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
   parameter int pTIMEOUT    = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset_i,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_we,
   input  logic [pDATA_WIDTH/8-1:0] cmd_be,
   input  logic [pADDR_WIDTH-1:0]   cmd_addr,
   input  logic [pDATA_WIDTH-1:0]   cmd_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ack,
   output logic [pDATA_WIDTH-1:0]   rsp_rdata,
   output logic                     rsp_err,
   output logic                     busy,
   output logic                     req,
   output logic                     we,
   output logic [pDATA_WIDTH/8-1:0] be,
   output logic [pADDR_WIDTH-1:0]   addr,
   output logic [pDATA_WIDTH-1:0]   wdata,
   input  logic                     gnt,
   input  logic                     rvalid,
   input  logic [pDATA_WIDTH-1:0]   rdata
);
   localparam int CW = $clog2(pTIMEOUT + 1);

   state_t                     r_state, w_state_nxt;
   logic [CW-1:0]              r_cnt;
   logic                       r_we;
   logic [pDATA_WIDTH/8-1:0]   r_be;
   logic [pADDR_WIDTH-1:0]     r_addr;
   logic [pDATA_WIDTH-1:0]     r_wdata;
   logic [pDATA_WIDTH-1:0]     r_rdata;
   logic                       r_err;
   logic                       w_active;
   logic                       w_timeout;
   logic                       w_accept;
   logic                       w_done;

   assign w_accept = (r_state == IDLE) && cmd_valid;
   assign w_active = (r_state == REQ) || (r_state == WAIT_R);
   // The cycle that would bring the count to pTIMEOUT is the last one allowed.
   assign w_timeout = w_active && (r_cnt == CW'(pTIMEOUT - 1));
   assign w_done = (r_state == WAIT_R) && rvalid && !w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = cmd_valid ? REQ : IDLE;
         REQ:     w_state_nxt = w_timeout ? RESP : (gnt ? WAIT_R : REQ);
         WAIT_R:  w_state_nxt = (w_timeout || rvalid) ? RESP : WAIT_R;
         default: w_state_nxt = rsp_ack ? IDLE : RESP;
      endcase
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_be    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt   <= '0;
            r_we    <= cmd_we;
            r_be    <= cmd_be;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
         end else if (w_active && r_cnt != CW'(pTIMEOUT)) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_done) begin
            r_rdata <= r_we ? '0 : rdata;
            r_err   <= 1'b0;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end
   end

   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign req       = (r_state == REQ);
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign we        = r_we;
   assign be        = r_be;
   assign addr      = r_addr;
   assign wdata     = r_wdata;
endmodule

// File: tb/tb_obi_host_initiator.sv
// tb_obi_host_initiator: directed OBI transactions; responses are checked by a
// scoreboard monitor, cycle-level behaviour by inline checks.
module tb_obi_host_initiator;
   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [3:0]  cmd_be = '0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        rsp_valid, rsp_ack = 1'b0, rsp_err, busy, req, we;
   logic [31:0] rsp_rdata;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = '0;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb_q[$];

   obi_host_initiator #(.pADDR_WIDTH(32), .pDATA_WIDTH(32), .pTIMEOUT(8)) dut (
      .clk(clk), .reset_i(reset_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_be(cmd_be),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_we    = w;
      cmd_be    = b;
      cmd_addr  = a;
      cmd_wdata = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic ack();
      rsp_ack = 1'b1;
      tick();
      rsp_ack = 1'b0;
      chk("rsp_valid_after_ack", rsp_valid, 0);
      chk("cmd_ready_after_ack", cmd_ready, 1);
   endtask

   initial begin : monitor
      logic        prev_v;
      logic [32:0] e_v;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid && !prev_v) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
            end else begin
               e_v = sb_q.pop_front();
               chk("sb_rsp_rdata", rsp_rdata, e_v[31:0]);
               chk("sb_rsp_err", rsp_err, e_v[32]);
            end
         end
         prev_v = rsp_valid;
      end
   end

   initial begin
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_req", req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_addr", addr, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      reset_i = 1'b0;
      tick();

      // Minimum-latency read
      sb_q.push_back({1'b0, 32'hDEAD_BEEF});
      send(1'b0, 4'hF, 32'h2000_0010, 32'h0);
      chk("rd_req", req, 1);
      chk("rd_addr", addr, 32'h2000_0010);
      chk("rd_we", we, 0);
      chk("rd_cmd_ready", cmd_ready, 0);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk("rd_req_after_gnt", req, 0);
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      tick();
      rvalid = 1'b0;
      chk("rd_rsp_valid_c3", rsp_valid, 1);
      ack();

      // Write with grant withheld for five cycles
      sb_q.push_back({1'b0, 32'h0});
      send(1'b1, 4'b0011, 32'h3000_0020, 32'h1234_5678);
      for (int i = 0; i < 6; i++) begin
         chk("wr_req_held", req, 1);
         chk("wr_addr_stable", addr, 32'h3000_0020);
         chk("wr_wdata_stable", wdata, 32'h1234_5678);
         chk("wr_be_stable", be, 4'b0011);
         chk("wr_we_stable", we, 1);
         gnt = (i == 5);
         tick();
      end
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hFFFF_FFFF;
      tick();
      rvalid = 1'b0;
      chk("wr_rsp_valid", rsp_valid, 1);
      ack();

      // Stray rvalid / rsp_ack in IDLE, rvalid in the grant cycle
      rvalid  = 1'b1;
      rsp_ack = 1'b1;
      tick();
      tick();
      rvalid  = 1'b0;
      rsp_ack = 1'b0;
      chk("stray_idle_ready", cmd_ready, 1);
      chk("stray_idle_busy", busy, 0);
      chk("stray_idle_rsp", rsp_valid, 0);
      send(1'b0, 4'hF, 32'h0000_0004, 32'h0);
      gnt    = 1'b1;
      rvalid = 1'b1;
      rdata  = 32'hBAD0_BAD0;
      tick();
      gnt    = 1'b0;
      rvalid = 1'b0;
      chk("stray_gnt_rsp", rsp_valid, 0);
      chk("stray_gnt_busy", busy, 1);
      tick();
      chk("stray_wait_rsp", rsp_valid, 0);
      chk("stray_wait_ready", cmd_ready, 0);
      sb_q.push_back({1'b0, 32'h0000_00A5});
      rvalid = 1'b1;
      rdata  = 32'h0000_00A5;
      tick();
      rvalid = 1'b0;
      ack();

      // Back-pressure: response held ten cycles, new commands ignored
      sb_q.push_back({1'b0, 32'hCAFE_F00D});
      send(1'b0, 4'hF, 32'h0000_0050, 32'h0);
      gnt = 1'b1;
      tick();
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hCAFE_F00D;
      tick();
      rvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
         chk("bp_cmd_ready", cmd_ready, 0);
         cmd_valid = 1'b1;
         cmd_we    = 1'b1;
         cmd_addr  = 32'h0000_0099;
         tick();
      end
      cmd_valid = 1'b0;
      chk("bp_addr_kept", addr, 32'h0000_0050);
      ack();
      tick();
      chk("bp_not_queued", busy, 0);

      // Timeout with gnt never asserted
      sb_q.push_back({1'b1, 32'h0});
      send(1'b0, 4'hF, 32'h0000_0060, 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk("to_req_held", req, 1);
         chk("to_no_rsp", rsp_valid, 0);
         tick();
      end
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);
      for (int i = 0; i < 2; i++) begin
         chk("to_req_low", req, 0);
         tick();
      end
      ack();

      // Reset pulsed in WAIT_R, then a late rvalid
      send(1'b0, 4'hF, 32'h0000_0070, 32'h0);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk("rs_in_wait", busy, 1);
      reset_i = 1'b1;
      #2;
      chk("rs_async_ready", cmd_ready, 1);
      chk("rs_async_addr", addr, 0);
      reset_i = 1'b0;
      rvalid  = 1'b1;
      rdata   = 32'h0000_1234;
      tick();
      tick();
      rvalid = 1'b0;
      chk("rs_no_rsp", rsp_valid, 0);
      chk("rs_idle", busy, 0);
      chk("rs_ready", cmd_ready, 1);
      tick();
      tick();
      chk("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
